signal_watchdog_mc: RTL and testbench

Multi-channel, parametrised successor to the single-antenna receiver signal watchdog. Sits between the RF sample stream and the `dot11` reset tree and monitors up to `NUM_CH` I/Q channels for DC-stuck/biased input. It also checks the decoded SIGNAL length against a window. When either check fails it issues a fixed-length `receiver_rst` pulse followed by a hold-off period, and reports the cause and saturating trip counters for driver readback.

---
 rtl/signal_watchdog_mc.sv | 177 +++++++++++++++++
 tb/tb_signal_watchdog_mc.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/signal_watchdog_mc.sv
// rtl/signal_watchdog_mc.sv - multi-channel DC-bias and SIGNAL-length receiver watchdog
// Issues a fixed receiver_rst pulse plus hold-off on a trip; reports cause and saturating trip counts.
module signal_watchdog_mc #(
    parameter int IQ_DATA_WIDTH = 16,
    parameter int NUM_CH        = 2,
    parameter int DC_WIN_LOG2   = 6,
    parameter int RST_PULSE_LEN = 4,
    parameter int HOLDOFF_LEN   = 32,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                              clock_i,
    input  logic                              reset_i,
    input  logic                              enable_i,
    input  logic [NUM_CH*2*IQ_DATA_WIDTH-1:0] sample_in_i,
    input  logic                              sample_in_strobe_i,
    input  logic                              power_trigger_i,
    input  logic                              sig_valid_i,
    input  logic [15:0]                       signal_len_i,
    input  logic [15:0]                       min_signal_len_th_i,
    input  logic [15:0]                       max_signal_len_th_i,
    input  logic [DC_WIN_LOG2:0]              dc_running_sum_th_i,
    input  logic [1:0]                        mode_i,
    input  logic [NUM_CH-1:0]                 ch_mask_i,
    output logic                              receiver_rst_o,
    output logic [1:0]                        rst_cause_o,
    output logic [CNT_WIDTH-1:0]              dc_trip_count_o,
    output logic [CNT_WIDTH-1:0]              len_trip_count_o
);

    localparam int W         = IQ_DATA_WIDTH;
    localparam int CW        = DC_WIN_LOG2 + 1;
    localparam int SW        = DC_WIN_LOG2 + 2;
    localparam int WIN_LEN_I = 1 << DC_WIN_LOG2;
    localparam logic [SW-1:0] WIN_LEN = SW'(WIN_LEN_I);
    localparam int TMR_MAX   = (RST_PULSE_LEN > HOLDOFF_LEN) ? RST_PULSE_LEN : HOLDOFF_LEN;
    localparam int TMR_W     = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
    localparam int HOLD_LAST_I = (HOLDOFF_LEN > 0) ? HOLDOFF_LEN - 1 : 0;
    localparam logic [TMR_W-1:0] RST_LAST  = TMR_W'(RST_PULSE_LEN - 1);
    localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(HOLD_LAST_I);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RST,
        S_HOLD
    } state_t;

    state_t                          state_q, state_d;
    logic [TMR_W-1:0]                tmr_q, tmr_d;
    logic [DC_WIN_LOG2-1:0]          win_cnt_q, win_cnt_d;
    logic [NUM_CH-1:0][CW-1:0]       pos_i_q, pos_i_d;
    logic [NUM_CH-1:0][CW-1:0]       pos_q_q, pos_q_d;
    logic                            dc_trip_q, dc_trip_d;
    logic [1:0]                      cause_q, cause_d;
    logic [CNT_WIDTH-1:0]            dc_cnt_q, dc_cnt_d;
    logic [CNT_WIDTH-1:0]            len_cnt_q, len_cnt_d;

    logic                            win_run;
    logic                            win_end;
    logic                            len_bad;
    logic [NUM_CH-1:0][CW-1:0]       fin_i;
    logic [NUM_CH-1:0][CW-1:0]       fin_q;
    logic [NUM_CH-1:0]               ch_trip;

    // A count is biased if it reaches th, or if count + th does not exceed the window length.
    function automatic logic dc_biased(input logic [CW-1:0] cnt, input logic [CW-1:0] th);
        return (cnt >= th) || (({1'b0, cnt} + {1'b0, th}) <= WIN_LEN);
    endfunction

    assign win_run = enable_i && (state_q == S_IDLE);
    assign win_end = win_run && sample_in_strobe_i && (&win_cnt_q);
    assign len_bad = sig_valid_i && mode_i[1] &&
                     ((signal_len_i < min_signal_len_th_i) || (signal_len_i > max_signal_len_th_i));

    always_comb begin
        fin_i     = '0;
        fin_q     = '0;
        ch_trip   = '0;
        win_cnt_d = win_cnt_q;
        pos_i_d   = pos_i_q;
        pos_q_d   = pos_q_q;
        for (int k = 0; k < NUM_CH; k++) begin
            fin_i[k]   = pos_i_q[k] + CW'(~sample_in_i[k*2*W + 2*W - 1]);
            fin_q[k]   = pos_q_q[k] + CW'(~sample_in_i[k*2*W + W - 1]);
            ch_trip[k] = ch_mask_i[k] &&
                         (dc_biased(fin_i[k], dc_running_sum_th_i) ||
                          dc_biased(fin_q[k], dc_running_sum_th_i));
        end
        if (!win_run) begin
            win_cnt_d = '0;
            pos_i_d   = '0;
            pos_q_d   = '0;
        end else if (sample_in_strobe_i) begin
            win_cnt_d = win_cnt_q + DC_WIN_LOG2'(1);
            if (&win_cnt_q) begin
                pos_i_d = '0;
                pos_q_d = '0;
            end else begin
                pos_i_d = fin_i;
                pos_q_d = fin_q;
            end
        end
        dc_trip_d = win_end && mode_i[0] && power_trigger_i && (|ch_trip);
    end

    always_comb begin
        state_d   = state_q;
        tmr_d     = tmr_q;
        cause_d   = cause_q;
        dc_cnt_d  = dc_cnt_q;
        len_cnt_d = len_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (dc_trip_q || len_bad) begin
                    state_d = S_RST;
                    tmr_d   = '0;
                    cause_d = {len_bad, dc_trip_q};
                    if (dc_trip_q && !(&dc_cnt_q)) begin
                        dc_cnt_d = dc_cnt_q + CNT_WIDTH'(1);
                    end
                    if (len_bad && !(&len_cnt_q)) begin
                        len_cnt_d = len_cnt_q + CNT_WIDTH'(1);
                    end
                end
            end
            S_RST: begin
                if (tmr_q == RST_LAST) begin
                    tmr_d   = '0;
                    state_d = (HOLDOFF_LEN == 0) ? S_IDLE : S_HOLD;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            S_HOLD: begin
                if (tmr_q == HOLD_LAST) begin
                    tmr_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                tmr_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q   <= S_IDLE;
            tmr_q     <= '0;
            win_cnt_q <= '0;
            pos_i_q   <= '0;
            pos_q_q   <= '0;
            dc_trip_q <= 1'b0;
            cause_q   <= '0;
            dc_cnt_q  <= '0;
            len_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            tmr_q     <= tmr_d;
            win_cnt_q <= win_cnt_d;
            pos_i_q   <= pos_i_d;
            pos_q_q   <= pos_q_d;
            dc_trip_q <= dc_trip_d;
            cause_q   <= cause_d;
            dc_cnt_q  <= dc_cnt_d;
            len_cnt_q <= len_cnt_d;
        end
    end

    assign receiver_rst_o   = (state_q == S_RST);
    assign rst_cause_o      = cause_q;
    assign dc_trip_count_o  = dc_cnt_q;
    assign len_trip_count_o = len_cnt_q;

endmodule

// File: tb/tb_signal_watchdog_mc.sv
// tb/tb_signal_watchdog_mc.sv - scoreboard bench for signal_watchdog_mc
// Two instances share stimulus: default counters and 2-bit counters for saturation.
module tb_signal_watchdog_mc;

    localparam int W   = 16;
    localparam int NCH = 2;
    localparam int L   = 6;
    localparam int P   = 4;
    localparam int H   = 32;
    localparam int WIN = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst, enable, strobe, ptrig, sig_valid;
    logic [NCH*2*W-1:0]   sample;
    logic [15:0]          slen, min_th, max_th;
    logic [L:0]           th;
    logic [1:0]           mode;
    logic [NCH-1:0]       mask;

    logic                 a_rst, b_rst;
    logic [1:0]           a_cause, b_cause;
    logic [15:0]          a_dcc, a_lc;
    logic [1:0]           b_dcc, b_lc;

    signal_watchdog_mc dut_a (
        .clock_i(clk), .reset_i(rst), .enable_i(enable), .sample_in_i(sample),
        .sample_in_strobe_i(strobe), .power_trigger_i(ptrig), .sig_valid_i(sig_valid),
        .signal_len_i(slen), .min_signal_len_th_i(min_th), .max_signal_len_th_i(max_th),
        .dc_running_sum_th_i(th), .mode_i(mode), .ch_mask_i(mask),
        .receiver_rst_o(a_rst), .rst_cause_o(a_cause),
        .dc_trip_count_o(a_dcc), .len_trip_count_o(a_lc)
    );

    signal_watchdog_mc #(.CNT_WIDTH(2)) dut_b (
        .clock_i(clk), .reset_i(rst), .enable_i(enable), .sample_in_i(sample),
        .sample_in_strobe_i(strobe), .power_trigger_i(ptrig), .sig_valid_i(sig_valid),
        .signal_len_i(slen), .min_signal_len_th_i(min_th), .max_signal_len_th_i(max_th),
        .dc_running_sum_th_i(th), .mode_i(mode), .ch_mask_i(mask),
        .receiver_rst_o(b_rst), .rst_cause_o(b_cause),
        .dc_trip_count_o(b_dcc), .len_trip_count_o(b_lc)
    );

    typedef struct {
        int rst;
        int cause;
        int dcc;
        int lc;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: edge index, pulse interval, first idle edge, current window contents.
    int                 t = 0;
    int                 idle_at = -1;
    int                 p_start = 1;
    int                 p_end = 0;
    bit                 dc_pend = 1'b0;
    int                 m_dcc = 0;
    int                 m_lc = 0;
    int                 m_cause = 0;
    logic [NCH*2*W-1:0] win[$];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    function automatic bit window_biased();
        int ci, cq, thv;
        logic [NCH*2*W-1:0] s;
        thv = int'(th);
        if (!(mode[0] && ptrig)) return 1'b0;
        for (int ch = 0; ch < NCH; ch++) begin
            if (mask[ch]) begin
                ci = 0;
                cq = 0;
                foreach (win[j]) begin
                    s = win[j];
                    if (!s[ch*2*W + 2*W - 1]) ci++;
                    if (!s[ch*2*W + W - 1]) cq++;
                end
                if (ci >= thv || ci <= WIN - thv || cq >= thv || cq <= WIN - thv) return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    // Applies the current inputs to the model for the next clock edge and queues the expected outputs.
    task automatic step();
        exp_t e;
        bit   idle, len_trip, dc_trip;
        if (rst) begin
            win.delete();
            dc_pend = 1'b0;
            m_cause = 0;
            m_dcc   = 0;
            m_lc    = 0;
            idle_at = t;
            p_start = 1;
            p_end   = 0;
        end else begin
            idle     = (t - 1 >= idle_at);
            len_trip = sig_valid && mode[1] && (slen < min_th || slen > max_th);
            dc_trip  = dc_pend;
            dc_pend  = 1'b0;
            if (enable && idle) begin
                if (strobe) begin
                    win.push_back(sample);
                    if (win.size() == WIN) begin
                        dc_pend = window_biased();
                        win.delete();
                    end
                end
            end else begin
                win.delete();
            end
            if (idle && (len_trip || dc_trip)) begin
                m_cause = {30'd0, len_trip, dc_trip};
                if (dc_trip) m_dcc++;
                if (len_trip) m_lc++;
                p_start = t;
                p_end   = t + P - 1;
                idle_at = t + P + H;
            end
        end
        e.rst   = (t >= p_start && t <= p_end) ? 1 : 0;
        e.cause = m_cause;
        e.dcc   = m_dcc;
        e.lc    = m_lc;
        sb.push_back(e);
        t++;
        @(negedge clk);
    endtask

    task automatic new_sample(input bit biased);
        sample = {$urandom, $urandom};
        if (biased) sample[1*2*W + W +: W] = 16'd100;
    endtask

    task automatic run(input int n, input bit biased);
        for (int i = 0; i < n; i++) begin
            new_sample(biased);
            step();
        end
    endtask

    task automatic len_event(input logic [15:0] len);
        sig_valid = 1'b1;
        slen      = len;
        new_sample(1'b0);
        step();
        sig_valid = 1'b0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("a_receiver_rst", int'(a_rst), e.rst);
                chk("a_rst_cause", int'(a_cause), e.cause);
                chk("a_dc_trip_count", int'(a_dcc), sat(e.dcc, 65535));
                chk("a_len_trip_count", int'(a_lc), sat(e.lc, 65535));
                chk("b_receiver_rst", int'(b_rst), e.rst);
                chk("b_rst_cause", int'(b_cause), e.cause);
                chk("b_dc_trip_count", int'(b_dcc), sat(e.dcc, 3));
                chk("b_len_trip_count", int'(b_lc), sat(e.lc, 3));
            end
        end
    end

    initial begin : driver
        bit biased;
        rst = 1'b1; enable = 1'b1; strobe = 1'b1; ptrig = 1'b1; sig_valid = 1'b0;
        sample = '0; slen = 16'd100; min_th = 16'd14; max_th = 16'd1600;
        th = 7'd56; mode = 2'b11; mask = 2'b11;
        run(3, 1'b0);
        rst = 1'b0;

        // Random-sign samples with occasional in-range lengths.
        for (int i = 0; i < 1000; i++) begin
            strobe    = ($urandom_range(7) != 0);
            sig_valid = ($urandom_range(19) == 0);
            slen      = 16'($urandom_range(1600, 14));
            new_sample(1'b0);
            step();
        end
        sig_valid = 1'b0;
        strobe    = 1'b1;

        // Channel 1 I stuck positive, then masked off.
        run(120, 1'b1);
        mask = 2'b01;
        run(150, 1'b1);
        mask = 2'b11;

        // Length window boundaries with DC check idle.
        enable = 1'b0;
        run(40, 1'b0);
        len_event(16'd10);    run(40, 1'b0);
        len_event(16'd14);    run(5, 1'b0);
        len_event(16'd1600);  run(5, 1'b0);
        len_event(16'd1601);  run(40, 1'b0);
        len_event(16'd13);    run(40, 1'b0);
        mode = 2'b01;
        len_event(16'd0);     run(5, 1'b0);
        mode = 2'b11;

        // Length trip on the DC compare cycle, then a bad length inside hold-off.
        enable = 1'b1;
        for (int i = 0; i < 200; i++) begin
            new_sample(1'b1);
            step();
            if (dc_pend) break;
        end
        len_event(16'd5);
        run(10, 1'b1);
        len_event(16'd3);
        enable = 1'b0;
        run(40, 1'b0);

        // Partial biased window discarded when enable drops.
        enable = 1'b1;
        run(40, 1'b1);
        enable = 1'b0;
        run(2, 1'b1);
        enable = 1'b1;
        run(100, 1'b1);
        enable = 1'b0;
        run(40, 1'b0);

        // Counter saturation on the 2-bit instance.
        for (int i = 0; i < 5; i++) begin
            len_event(16'd2000);
            run(40, 1'b0);
        end

        // Reset in the middle of a pulse.
        len_event(16'd1);
        run(2, 1'b0);
        rst = 1'b1;
        run(1, 1'b0);
        rst = 1'b0;
        run(5, 1'b0);

        // Mixed random traffic.
        biased = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(99) == 0) biased = ~biased;
            enable    = ($urandom_range(9) != 0);
            strobe    = ($urandom_range(3) != 0);
            ptrig     = ($urandom_range(3) != 0);
            if ($urandom_range(199) == 0) mode = 2'($urandom_range(3));
            if ($urandom_range(199) == 0) mask = 2'($urandom_range(3));
            if ($urandom_range(199) == 0) th = 7'($urandom_range(64, 40));
            sig_valid = ($urandom_range(29) == 0);
            slen      = 16'($urandom_range(1700, 0));
            rst       = ($urandom_range(499) == 0);
            new_sample(biased);
            step();
        end
        rst = 1'b0; sig_valid = 1'b0;
        run(3, 1'b0);

        @(posedge clk);
        #4;
        chk("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
